lu_pipe_n: RTL and testbench

- Parametrised, registered logic unit.
- Successor to the 1-bit combinational AND/NAND/OR/NOR unit: WIDTH-bit operands, 8 operations, valid/ready handshake, accumulator mode, result flags and a saturating operation counter.
- Sits between the operand register file and the writeback stage of the teaching datapath.

---
 rtl/lu_pipe_n_if.sv | 27 ++
 rtl/lu_pipe_n.sv | 52 +++++
 tb/tb_lu_pipe_n.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lu_pipe_n_if.sv
// lu_pipe_n_if: operand/result handshake bundle for the registered logic unit
interface lu_pipe_n_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;
  logic             ones;
  logic             parity;
  logic [CNT_W-1:0] op_count;
  modport master (
    output in_valid, a, b, op, acc_en, out_ready,
    input  in_ready, out_valid, s, zero, ones, parity, op_count
  );
  modport slave (
    input  in_valid, a, b, op, acc_en, out_ready,
    output in_ready, out_valid, s, zero, ones, parity, op_count
  );
endinterface

// File: rtl/lu_pipe_n.sv
// lu_pipe_n: registered WIDTH-bit logic unit with accumulator, flags and saturating op counter
module lu_pipe_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  lu_pipe_n_if.slave  bus
);
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_acc;
  logic             r_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rdy;
  logic             w_accept;
  logic             w_inv;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_f;
  // Ops pair up as f/~f on op[0]; the 11x pair is inverted (NOT A, then PASS A).
  always_comb begin
    w_rdy    = !r_vld || bus.out_ready;
    w_accept = bus.in_valid && w_rdy;
    w_b      = bus.acc_en ? r_acc : bus.b;
    w_base   = (bus.op[2:1] == 2'b00) ? (bus.a & w_b) :
               (bus.op[2:1] == 2'b01) ? (bus.a | w_b) :
               (bus.op[2:1] == 2'b10) ? (bus.a ^ w_b) : bus.a;
    w_inv    = bus.op[0] ^ (bus.op[2] & bus.op[1]);
    w_f      = w_inv ? ~w_base : w_base;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_acc <= '0;
      r_vld <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s   <= w_accept ? w_f : r_s;
      r_acc <= clear ? '0 : w_accept ? w_f : r_acc;
      r_vld <= w_accept || (r_vld && !bus.out_ready);
      r_cnt <= clear ? '0 : (w_accept && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign bus.in_ready  = w_rdy;
  assign bus.out_valid = r_vld;
  assign bus.s         = r_s;
  assign bus.zero      = ~|r_s;
  assign bus.ones      = &r_s;
  assign bus.parity    = ^r_s;
  assign bus.op_count  = r_cnt;
endmodule

// File: tb/tb_lu_pipe_n.sv
// tb_lu_pipe_n: scoreboard bench driving an 8-bit-counter and a 2-bit-counter unit in lockstep
module tb_lu_pipe_n;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic [2:0] op_i = '0;
  logic       ae = 1'b0;
  logic       ordy = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic       m_vld;
  logic [7:0] m_acc;
  int         c8;
  int         c2;

  lu_pipe_n_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  lu_pipe_n_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  lu_pipe_n #(.WIDTH(8), .CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .clear(clr), .bus(bus8));
  lu_pipe_n #(.WIDTH(8), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .clear(clr), .bus(bus2));

  assign bus8.in_valid = valid;
  assign bus8.a = a_i;
  assign bus8.b = b_i;
  assign bus8.op = op_i;
  assign bus8.acc_en = ae;
  assign bus8.out_ready = ordy;
  assign bus2.in_valid = valid;
  assign bus2.a = a_i;
  assign bus2.b = b_i;
  assign bus2.op = op_i;
  assign bus2.acc_en = ae;
  assign bus2.out_ready = ordy;

  always #5 clk = ~clk;

  task automatic model_reset();
    m_vld = 1'b0;
    m_acc = '0;
    c8 = 0;
    c2 = 0;
    q.delete();
  endtask

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [2:0] top, input logic tae, input logic tr, input logic tc);
    valid = v;
    a_i = ta;
    b_i = tb;
    op_i = top;
    ae = tae;
    ordy = tr;
    clr = tc;
  endtask

  task automatic tick();
    logic       acc;
    logic [7:0] eb;
    logic [7:0] f;
    acc = valid && (!m_vld || ordy);
    eb = ae ? m_acc : b_i;
    case (op_i)
      3'd0: f = a_i & eb;
      3'd1: f = ~(a_i & eb);
      3'd2: f = a_i | eb;
      3'd3: f = ~(a_i | eb);
      3'd4: f = a_i ^ eb;
      3'd5: f = ~(a_i ^ eb);
      3'd6: f = ~a_i;
      default: f = a_i;
    endcase
    @(posedge clk);
    #1;
    if (acc) q.push_back(f);
    m_vld = acc || (m_vld && !ordy);
    m_acc = clr ? 8'h00 : acc ? f : m_acc;
    if (clr) begin
      c8 = 0;
      c2 = 0;
    end else if (acc) begin
      if (c8 != 255) c8++;
      if (c2 != 3) c2++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.s !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.op_count !== 8'h00 ||
        bus8.zero !== 1'b1 || bus8.ones !== 1'b0 || bus8.parity !== 1'b0) begin
      errors++;
      $display("FAIL reset: s=%h vld=%b cnt=%h z=%b o=%b p=%b exp s=00 vld=0 cnt=00 z=1 o=0 p=0",
               bus8.s, bus8.out_valid, bus8.op_count, bus8.zero, bus8.ones, bus8.parity);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_all_ops();
    logic [7:0] tbl [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b1, 1'b0);
      tick();
      exp = q.pop_front();
      checks++;
      if (bus8.s !== exp || bus8.s !== tbl[i] || bus8.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL op%0d: s=%h vld=%b exp s=%h vld=1", i, bus8.s, bus8.out_valid, tbl[i]);
      end
      if (i == 4) begin
        checks++;
        if (bus8.parity !== 1'b0 || bus8.zero !== 1'b0 || bus8.ones !== 1'b0) begin
          errors++;
          $display("FAIL flags_3c: p=%b z=%b o=%b exp p=0 z=0 o=0", bus8.parity, bus8.zero, bus8.ones);
        end
      end
    end
    checks++;
    if (bus8.op_count !== 8'(c8) || c8 != 8) begin
      errors++;
      $display("FAIL count_ops: got %0d exp 8", bus8.op_count);
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.s !== 8'hF0) begin
      errors++;
      $display("FAIL drain: vld=%b s=%h exp vld=0 s=f0", bus8.out_valid, bus8.s);
    end
  endtask

  task automatic test_acc_chain();
    logic [7:0] exp;
    logic [7:0] want [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [7:0] as [3] = '{8'h0F, 8'hF0, 8'hFF};
    logic [2:0] ops [3] = '{3'd2, 3'd4, 3'd0};
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus8.op_count !== 8'h00) begin
      errors++;
      $display("FAIL clear_cnt: got %h exp 00", bus8.op_count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, as[i], 8'h33, ops[i], 1'b1, 1'b1, 1'b0);
      tick();
      exp = q.pop_front();
      checks++;
      if (bus8.s !== exp || bus8.s !== want[i]) begin
        errors++;
        $display("FAIL acc%0d: s=%h exp %h", i, bus8.s, want[i]);
      end
    end
    checks++;
    if (bus8.ones !== 1'b1 || bus8.zero !== 1'b0 || bus8.parity !== 1'b0) begin
      errors++;
      $display("FAIL flags_ff: o=%b z=%b p=%b exp o=1 z=0 p=0", bus8.ones, bus8.zero, bus8.parity);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    int cnt0;
    drive(1'b1, 8'hAA, 8'h00, 3'd7, 1'b0, 1'b1, 1'b0);
    tick();
    exp = q.pop_front();
    cnt0 = c8;
    checks++;
    if (bus8.s !== exp || bus8.s !== 8'hAA) begin
      errors++;
      $display("FAIL bp_first: s=%h exp aa", bus8.s);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'b0, 1'b0);
      #1;
      checks++;
      if (bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b exp 0", i, bus8.in_ready);
      end
      tick();
      checks++;
      if (bus8.s !== 8'hAA || bus8.out_valid !== 1'b1 || bus8.op_count !== 8'(cnt0)) begin
        errors++;
        $display("FAIL bp_hold%0d: s=%h vld=%b cnt=%0d exp s=aa vld=1 cnt=%0d",
                 i, bus8.s, bus8.out_valid, bus8.op_count, cnt0);
      end
    end
    drive(1'b1, 8'h55, 8'h00, 3'd7, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b exp 1", bus8.in_ready);
    end
    tick();
    exp = q.pop_front();
    checks++;
    if (bus8.s !== exp || bus8.s !== 8'h55 || bus8.op_count !== 8'(cnt0 + 1) || q.size() != 0) begin
      errors++;
      $display("FAIL bp_resume: s=%h cnt=%0d pending=%0d exp s=55 cnt=%0d pending=0",
               bus8.s, bus8.op_count, q.size(), cnt0 + 1);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] exp;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(i), 8'h00, 3'd7, 1'b0, 1'b1, 1'b0);
      tick();
      void'(q.pop_front());
      checks++;
      if (bus2.op_count !== want[i] || bus2.op_count !== 2'(c2)) begin
        errors++;
        $display("FAIL sat%0d: got %0d exp %0d", i, bus2.op_count, want[i]);
      end
    end
    drive(1'b1, 8'hFF, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
    tick();
    exp = q.pop_front();
    checks++;
    if (bus2.op_count !== 2'd0 || bus8.op_count !== 8'd0 || bus2.s !== exp || bus2.s !== 8'h04) begin
      errors++;
      $display("FAIL clr_accept: cnt2=%0d cnt8=%0d s=%h exp cnt=0 s=04", bus2.op_count, bus8.op_count, bus2.s);
    end
    drive(1'b1, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    exp = q.pop_front();
    checks++;
    if (bus2.s !== exp || bus2.s !== 8'hFF || bus2.op_count !== 2'd1) begin
      errors++;
      $display("FAIL acc_cleared: s=%h cnt=%0d exp s=ff cnt=1", bus2.s, bus2.op_count);
    end
    drive(1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
    tick();
    void'(q.pop_front());
    drive(1'b1, 8'h0F, 8'hFF, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    exp = q.pop_front();
    checks++;
    if (bus2.s !== exp || bus2.s !== 8'h0F) begin
      errors++;
      $display("FAIL acc_zero: s=%h exp 0f", bus2.s);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    drive(1'b1, 8'h3C, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.s !== 8'h00 || bus8.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: vld=%b s=%h z=%b exp vld=0 s=00 z=1", bus8.out_valid, bus8.s, bus8.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 8'hA5, 8'h5A, 3'd4, 1'b0, 1'b1, 1'b0);
    tick();
    exp = q.pop_front();
    checks++;
    if (bus8.s !== exp || bus8.s !== 8'hFF || bus8.out_valid !== 1'b1 || bus8.op_count !== 8'd1) begin
      errors++;
      $display("FAIL after_reset: s=%h vld=%b cnt=%0d exp s=ff vld=1 cnt=1",
               bus8.s, bus8.out_valid, bus8.op_count);
    end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_acc_chain();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
